// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage MIPS core: miss freeze, redirect flush, load-use bubble, miss watchdog.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UseRt,
    input  logic       EX_MemtoReg,
    input  logic [4:0] EX_WR_out,
    input  logic       EX_Redirect,
    input  logic       IC_Stall,
    input  logic       DC_Stall,
    output logic       PCWrite,
    output logic       IF_IDWrite,
    output logic       IF_Flush,
    output logic       ID_EXWrite,
    output logic       ID_Flush,
    output logic       EX_MEMWrite,
    output logic       MEM_WBWrite,
    output logic       Err_Timeout
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Bubble_Cnt
`endif
);

    localparam int WD_W = ((TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)) + (CNT_W - CNT_W);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WD_W-1:0] wd, wd_nx, wd_inc;
    logic            miss, load_use, frz_cyc, bub_cyc;

    assign miss     = IC_Stall | DC_Stall;
    assign load_use = EX_MemtoReg && (EX_WR_out != 5'd0) &&
                      ((EX_WR_out == ID_Rs) || (ID_UseRt && (EX_WR_out == ID_Rt)));
    assign wd_inc   = wd + 1'b1;

    // State and watchdog move on the falling edge, with the pipeline registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            wd    <= '0;
        end else begin
            state <= state_nx;
            wd    <= wd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wd_nx    = wd;
        case (state)
            RUN, FREEZE: begin
                if (miss) begin
                    wd_nx    = wd_inc;
                    state_nx = (wd_inc == WD_W'(TIMEOUT)) ? ERR : FREEZE;
                end else begin
                    wd_nx    = '0;
                    state_nx = RUN;
                end
            end
            ERR:     state_nx = ERR;
            default: begin
                state_nx = RUN;
                wd_nx    = '0;
            end
        endcase
    end

    always_comb begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        ID_EXWrite  = 1'b1;
        EX_MEMWrite = 1'b1;
        MEM_WBWrite = 1'b1;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        frz_cyc     = 1'b0;
        bub_cyc     = 1'b0;
        if (!rst) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            MEM_WBWrite = 1'b0;
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
        end else if (state == ERR || miss) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXWrite  = 1'b0;
            EX_MEMWrite = 1'b0;
            MEM_WBWrite = 1'b0;
            frz_cyc     = 1'b1;
        end else if (EX_Redirect) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
            bub_cyc  = 1'b1;
        end else if (load_use) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_Flush   = 1'b1;
            bub_cyc    = 1'b1;
        end
    end

    assign Err_Timeout = (state == ERR);

`ifdef HAZ_PERF_EN
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            Stall_Cnt  <= '0;
            Bubble_Cnt <= '0;
        end else begin
            if (frz_cyc && (Stall_Cnt != {CNT_W{1'b1}}))
                Stall_Cnt <= Stall_Cnt + 1'b1;
            if (bub_cyc && (Bubble_Cnt != {CNT_W{1'b1}}))
                Bubble_Cnt <= Bubble_Cnt + 1'b1;
        end
    end
`else
    logic perf_unused;
    assign perf_unused = frz_cyc ^ bub_cyc;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random traffic against a run-length model.
module tb_pipe_hazard_ctrl;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, EX_WR_out;
    logic       ID_UseRt, EX_MemtoReg, EX_Redirect, IC_Stall, DC_Stall;
    logic       PCWrite, IF_IDWrite, IF_Flush, ID_EXWrite, ID_Flush, EX_MEMWrite, MEM_WBWrite, Err_Timeout;
`ifdef HAZ_PERF_EN
    logic [31:0] Stall_Cnt, Bubble_Cnt;
`endif

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_MemtoReg(EX_MemtoReg), .EX_WR_out(EX_WR_out), .EX_Redirect(EX_Redirect),
        .IC_Stall(IC_Stall), .DC_Stall(DC_Stall),
        .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_Flush(IF_Flush),
        .ID_EXWrite(ID_EXWrite), .ID_Flush(ID_Flush),
        .EX_MEMWrite(EX_MEMWrite), .MEM_WBWrite(MEM_WBWrite),
        .Err_Timeout(Err_Timeout)
`ifdef HAZ_PERF_EN
        , .Stall_Cnt(Stall_Cnt), .Bubble_Cnt(Bubble_Cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: sticky error flag, length of the current miss run, event totals since reset
    bit m_err;
    int m_run;
    int m_stalls;
    int m_bubbles;

    function automatic logic [6:0] outs();
        return {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite, IF_Flush, ID_Flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_lu();
        return EX_MemtoReg && EX_WR_out != 0 &&
               (EX_WR_out == ID_Rs || (ID_UseRt && EX_WR_out == ID_Rt));
    endfunction

    // order: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, IF flush, ID flush
    function automatic logic [6:0] model_outs();
        if (!rst)                            return 7'b0000011;
        if (m_err || IC_Stall || DC_Stall)   return 7'b0000000;
        if (EX_Redirect)                     return 7'b1111111;
        if (is_lu())                         return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic model_reset();
        m_err = 0; m_run = 0; m_stalls = 0; m_bubbles = 0;
    endtask

    // compare at the rising edge (outputs stable), then advance the model to the coming falling edge
    task automatic step();
        @(posedge clk);
        chk("outs", {25'd0, outs()}, {25'd0, model_outs()});
        chk("err", {31'd0, Err_Timeout}, {31'd0, (rst && m_err)});
`ifdef HAZ_PERF_EN
        chk("stall_cnt", Stall_Cnt, m_stalls);
        chk("bubble_cnt", Bubble_Cnt, m_bubbles);
`endif
        if (!rst) model_reset();
        else if (m_err) m_stalls++;
        else if (IC_Stall || DC_Stall) begin
            m_run++; m_stalls++;
            if (m_run == TO) m_err = 1;
        end else begin
            m_run = 0;
            if (EX_Redirect || is_lu()) m_bubbles++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs = 0; ID_Rt = 0; ID_UseRt = 0; EX_MemtoReg = 0; EX_WR_out = 0;
        EX_Redirect = 0; IC_Stall = 0; DC_Stall = 0;
    endtask

    task automatic pulse_reset();
        rst = 0; idle(); #1;
        chk("reset_outs", {25'd0, outs()}, 32'h03);
        step();
        rst = 1; #1;
        chk("post_reset_outs", {25'd0, outs()}, 32'h7C);
    endtask

    int stall_left;

    initial begin
        model_reset();
        rst = 0; idle(); #1;
        chk("reset_outs0", {25'd0, outs()}, 32'h03);
        chk("reset_err", {31'd0, Err_Timeout}, 0);
        step(); step();
        rst = 1; #1;
        chk("run_idle", {25'd0, outs()}, 32'h7C);
        step();

        // load-use on Rt, exactly one bubble
        EX_MemtoReg = 1; EX_WR_out = 8; ID_Rt = 8; ID_UseRt = 1; ID_Rs = 3; #1;
        chk("lu_outs", {25'd0, outs()}, 32'h1D);
        step();
        EX_MemtoReg = 0; #1;
        chk("lu_gone", {25'd0, outs()}, 32'h7C);
        step();
        // load to $zero never stalls
        EX_MemtoReg = 1; EX_WR_out = 0; ID_Rt = 0; ID_Rs = 0; #1;
        chk("lu_zero", {25'd0, outs()}, 32'h7C);
        step();
        // redirect beats load-use
        EX_WR_out = 8; ID_Rt = 8; EX_Redirect = 1; #1;
        chk("redir_lu", {25'd0, outs()}, 32'h7F);
        step();
        idle(); step();

        // 5-cycle D-miss with a redirect held in EX
        pulse_reset();
        DC_Stall = 1; EX_Redirect = 1;
        for (int i = 0; i < 5; i++) begin
            #1; chk("dmiss_frz", {25'd0, outs()}, 32'h00);
            step();
        end
        DC_Stall = 0; #1;
        chk("dmiss_exit", {25'd0, outs()}, 32'h7F);
        step();
        EX_Redirect = 0; #1;
`ifdef HAZ_PERF_EN
        chk("lit_stall_cnt", Stall_Cnt, 5);
        chk("lit_bubble_cnt", Bubble_Cnt, 1);
`endif
        step();

        // overlapping I/D misses form one 7-cycle freeze
        for (int i = 0; i < 8; i++) begin
            IC_Stall = (i <= 3); DC_Stall = (i >= 2 && i <= 6); #1;
            chk("overlap", {25'd0, outs()}, (i < 7) ? 32'h00 : 32'h7C);
            step();
        end

        // watchdog
        pulse_reset();
        IC_Stall = 1;
        for (int i = 0; i < 20; i++) begin
            #1; chk("wd_err", {31'd0, Err_Timeout}, (i >= TO) ? 1 : 0);
            step();
        end
        IC_Stall = 0; #1;
        chk("err_frozen", {25'd0, outs()}, 32'h00);
        chk("err_sticky", {31'd0, Err_Timeout}, 1);
        step();
        rst = 0; #1;
        chk("err_cleared", {31'd0, Err_Timeout}, 0);
        step();
        rst = 1; step();

        // random traffic
        stall_left = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 249) != 0);
            if (stall_left == 0 && $urandom_range(0, 9) == 0)
                stall_left = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 22) : $urandom_range(1, 6);
            if (stall_left > 0) begin
                stall_left--;
                case ($urandom_range(0, 2))
                    0: begin IC_Stall = 1; DC_Stall = 0; end
                    1: begin IC_Stall = 0; DC_Stall = 1; end
                    default: begin IC_Stall = 1; DC_Stall = 1; end
                endcase
            end else begin
                IC_Stall = 0; DC_Stall = 0;
            end
            ID_Rs       = 5'($urandom_range(0, 3));
            ID_Rt       = 5'($urandom_range(0, 3));
            EX_WR_out   = 5'($urandom_range(0, 3));
            ID_UseRt    = 1'($urandom_range(0, 1));
            EX_MemtoReg = 1'($urandom_range(0, 1));
            EX_Redirect = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It arbitrates between cache-miss freezes, taken-control-flow flushes and load-use bubbles, and it runs a miss-stall watchdog. It sits beside the pipeline registers and samples their stage outputs.

## Interface
Parameters:
- `TIMEOUT`, default 1023: maximum consecutive miss-freeze cycles before `Err_Timeout` sets.
- `CNT_W`, default 32: width of the performance counters. Used only with `HAZ_PERF_EN`.

Ports:
- `clk` input, 1: core clock. All state updates on the falling edge, matching the pipeline registers.
- `rst` input, 1: reset, asynchronous, active-low.
- `ID_Rs` input, 5: Rs field of the instruction in ID.
- `ID_Rt` input, 5: Rt field of the instruction in ID.
- `ID_UseRt` input, 1: the ID instruction reads Rt (R-type, store, branch).
- `EX_MemtoReg` input, 1: the EX instruction is a load.
- `EX_WR_out` input, 5: destination register of the EX instruction.
- `EX_Redirect` input, 1: the EX instruction redirects the PC (taken branch, jump, jr, jal).
- `IC_Stall` input, 1: instruction cache miss in progress.
- `DC_Stall` input, 1: data cache miss in progress.
- `PCWrite` output, 1: PC register write enable.
- `IF_IDWrite` output, 1: IF/ID register write enable.
- `IF_Flush` output, 1: IF/ID register flush.
- `ID_EXWrite` output, 1: ID/EX register write enable.
- `ID_Flush` output, 1: ID/EX register flush.
- `EX_MEMWrite` output, 1: EX/MEM register write enable.
- `MEM_WBWrite` output, 1: MEM/WB register write enable.
- `Err_Timeout` output, 1: sticky watchdog error.
- `Stall_Cnt` output, CNT_W: miss-freeze cycle count. Present only with `HAZ_PERF_EN`.
- `Bubble_Cnt` output, CNT_W: load-use bubble plus flush event count. Present only with `HAZ_PERF_EN`.

## Operation
State machine with states RUN, FREEZE and ERR, encoded in 2 bits. Control outputs are combinational from the state and current inputs. The state, the watchdog counter and the performance counters are registered.

Output rules by state:
- RUN, no hazard: all `*Write` = 1 and both flushes = 0.
- Freeze, applies whenever `IC_Stall|DC_Stall` is 1 in RUN or FREEZE:
  - all `*Write` = 0 and both flushes = 0.
  - The state goes to FREEZE.
- Redirect, applies in RUN when there is no freeze and `EX_Redirect` = 1:
  - all writes = 1, `IF_Flush` = 1, `ID_Flush` = 1.
  - The two wrong-path instructions are squashed.
- Load-use, applies in RUN when there is no freeze, no redirect, `EX_MemtoReg` = 1, `EX_WR_out` != 0, and `EX_WR_out` == `ID_Rs`, or `EX_WR_out` == `ID_Rt` with `ID_UseRt` = 1:
  - `PCWrite` = 0, `IF_IDWrite` = 0, `ID_EXWrite` = 1, `ID_Flush` = 1. This inserts one bubble.
  - `EX_MEMWrite` = `MEM_WBWrite` = 1.

Priority: reset > freeze > redirect > load-use.

Freeze exit:
- FREEZE returns to RUN on the first falling edge where `IC_Stall|DC_Stall` = 0.
- The outputs in that same cycle follow the RUN rules. A redirect or load-use held frozen in EX is therefore applied on the exit cycle.

Watchdog:
- The watchdog counter clears in RUN and increments each FREEZE cycle.
- When it reaches `TIMEOUT`, the state goes to ERR and `Err_Timeout` sets.
- ERR holds all outputs at freeze values until reset. It ignores the stall inputs.

## Timing
Reset values while `rst` = 0:
- State RUN, watchdog 0, counters 0, `Err_Timeout` = 0.
- `PCWrite`, `IF_IDWrite`, `ID_EXWrite`, `EX_MEMWrite` and `MEM_WBWrite` = 0.
- `IF_Flush` = `ID_Flush` = 1.

Latency and cycle behaviour:
- Control outputs respond to input changes in the same cycle, with zero latency.
- A load-use hazard costs exactly 1 cycle. The bubble makes `EX_MemtoReg` 0 on the next cycle, so the hazard does not repeat.
- A redirect costs 2 squashed slots.
- A miss of N cycles freezes for exactly N cycles. `IC_Stall` and `DC_Stall` asserted together, or overlapping, form one freeze.

Boundary cases:
- Redirect and load-use in the same cycle: the redirect wins and no stall is applied.
- Miss asserting on the exit cycle of a previous freeze: stay in FREEZE. The watchdog continues counting from its current value.
- Reset mid-freeze returns the block to RUN asynchronously.

## Configuration
`HAZ_PERF_EN`:
- Defined:
  - `Stall_Cnt` increments each FREEZE or ERR cycle.
  - `Bubble_Cnt` increments each load-use or redirect cycle.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst` = 0 → all writes 0, both flushes 1, `Err_Timeout` 0. Release `rst` with no hazards → all writes 1, both flushes 0.
- Load-use: EX load with `EX_WR_out` = 8, `ID_Rt` = 8, `ID_UseRt` = 1 → exactly one cycle of `PCWrite` = 0, `IF_IDWrite` = 0, `ID_Flush` = 1. `EX_WR_out` = 0 produces no stall.
- Redirect plus load-use in the same cycle → `IF_Flush` = `ID_Flush` = 1, `PCWrite` = 1, no stall cycle.
- `DC_Stall` for 5 cycles, with `EX_Redirect` held throughout → 5 cycles with all writes 0. On the 6th cycle the flushes assert. With `HAZ_PERF_EN`, `Stall_Cnt` = 5 and `Bubble_Cnt` = 1.
- `IC_Stall` cycles 0–3 overlapping `DC_Stall` cycles 2–6 → one continuous 7-cycle freeze.
- `TIMEOUT` = 15, `IC_Stall` held for 20 cycles → `Err_Timeout` rises after 15 freeze cycles. Outputs stay frozen after `IC_Stall` drops. Asserting `rst` clears the error.
